// File: rtl/fuzz_top_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fuzz_top_pkg: shared widths, opcode encoding and flat-bus offsets     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package fuzz_top_pkg;

  localparam int LANES = 8;
  localparam int OPW   = 32;
  localparam int ACCW  = 40;

  localparam int OP_W     = 3;
  localparam int SHAMT_W  = 5;
  localparam int IN_W     = LANES * OPW + LANES * OP_W + 1;
  localparam int OUT_W    = LANES * ACCW + LANES + 2;

  localparam int OP_BASE  = LANES * OPW;
  localparam int EN_BIT   = OP_BASE + LANES * OP_W;
  localparam int SAT_BASE = LANES * ACCW;
  localparam int ZERO_BIT = SAT_BASE + LANES;
  localparam int PAR_BIT  = ZERO_BIT + 1;

  localparam logic [ACCW-1:0] ACC_MAX_POS = {1'b0, {(ACCW-1){1'b1}}};
  localparam logic [ACCW-1:0] ACC_MAX_NEG = {1'b1, {(ACCW-1){1'b0}}};

  typedef enum logic [OP_W-1:0] {
    OP_HOLD = 3'd0,
    OP_LOAD = 3'd1,
    OP_ADD  = 3'd2,
    OP_SUB  = 3'd3,
    OP_XOR  = 3'd4,
    OP_SHL  = 3'd5,
    OP_CLR  = 3'd6,
    OP_SADD = 3'd7
  } op_e;

endpackage
`default_nettype wire

// File: rtl/fuzz_top_lane.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fuzz_top_lane: one 40-bit accumulator, sticky saturation flag, ALU   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fuzz_top_lane
  import fuzz_top_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_en,
  input  op_e             i_op,
  input  logic [OPW-1:0]  i_a,
  output logic [ACCW-1:0] o_acc,
  output logic            o_sat
);

  logic [ACCW-1:0] r_acc;
  logic            r_sat;

  logic [ACCW-1:0] w_a_sext;
  logic [ACCW-1:0] w_a_zext;
  logic [ACCW-1:0] w_sum;
  logic [ACCW-1:0] w_diff;
  logic            w_ovf;
  logic [ACCW-1:0] w_acc_nxt;
  logic            w_sat_nxt;

  assign w_a_sext = {{(ACCW-OPW){i_a[OPW-1]}}, i_a};
  assign w_a_zext = {{(ACCW-OPW){1'b0}}, i_a};
  assign w_sum    = r_acc + w_a_sext;
  assign w_diff   = r_acc - w_a_sext;

  // Signed overflow: both addends share a sign the sum does not.
  assign w_ovf = (r_acc[ACCW-1] == w_a_sext[ACCW-1]) &&
                 (w_sum[ACCW-1] != r_acc[ACCW-1]);

  always_comb begin
    w_acc_nxt = r_acc;
    w_sat_nxt = r_sat;
    if (i_en) begin
      case (i_op)
        OP_HOLD: w_acc_nxt = r_acc;
        OP_LOAD: w_acc_nxt = w_a_zext;
        OP_ADD:  w_acc_nxt = w_sum;
        OP_SUB:  w_acc_nxt = w_diff;
        OP_XOR:  w_acc_nxt = r_acc ^ w_a_zext;
        OP_SHL:  w_acc_nxt = r_acc << i_a[SHAMT_W-1:0];
        OP_CLR: begin
          w_acc_nxt = '0;
          w_sat_nxt = 1'b0;
        end
        OP_SADD: begin
          if (w_ovf) begin
            w_acc_nxt = r_acc[ACCW-1] ? ACC_MAX_NEG : ACC_MAX_POS;
            w_sat_nxt = 1'b1;
          end else begin
            w_acc_nxt = w_sum;
          end
        end
        default: w_acc_nxt = r_acc;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_sat <= 1'b0;
    end else begin
      r_acc <= w_acc_nxt;
      r_sat <= w_sat_nxt;
    end
  end

  assign o_acc = r_acc;
  assign o_sat = r_sat;

endmodule
`default_nettype wire

// File: rtl/fuzz_top.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fuzz_top: eight-lane registered accumulator behind flat in/out buses |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fuzz_top
  import fuzz_top_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  in_flat,
  output logic [OUT_W-1:0] out_flat
);

  // rst_n is an active-high synchronous reset despite its name.
  logic                       w_en;
  logic [LANES*ACCW-1:0]      w_accs;
  logic [LANES-1:0]           w_sats;

  assign w_en = in_flat[EN_BIT];

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lanes
      fuzz_top_lane u_lane (
        .clk   (clk),
        .rst   (rst_n),
        .i_en  (w_en),
        .i_op  (op_e'(in_flat[OP_BASE + OP_W*gi +: OP_W])),
        .i_a   (in_flat[OPW*gi +: OPW]),
        .o_acc (w_accs[ACCW*gi +: ACCW]),
        .o_sat (w_sats[gi])
      );
    end
  endgenerate

  assign out_flat[SAT_BASE-1:0]         = w_accs;
  assign out_flat[SAT_BASE +: LANES]    = w_sats;
  assign out_flat[ZERO_BIT]             = ~|w_accs;
  assign out_flat[PAR_BIT]              = ^w_accs;

endmodule
`default_nettype wire

// File: tb/tb_fuzz_top.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fuzz_top: random stimulus against a behavioural lane model        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_fuzz_top;
  import fuzz_top_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [IN_W-1:0]  in_flat = '0;
  logic [OUT_W-1:0] out_flat;

  fuzz_top dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_flat  (in_flat),
    .out_flat (out_flat)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] s_a  [LANES];
  logic [2:0]  s_op [LANES];
  logic        s_en;

  logic [39:0] m_acc [LANES];
  bit          m_sat [LANES];

  localparam logic [OUT_W-1:0] RESET_VEC = {2'b01, {(OUT_W-2){1'b0}}};

  task automatic check(input string name, input logic [OUT_W-1:0] act,
                       input logic [OUT_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [IN_W-1:0] pack_in();
    logic [IN_W-1:0] v = '0;
    for (int i = 0; i < LANES; i++) begin
      v[32*i +: 32]      = s_a[i];
      v[256 + 3*i +: 3]  = s_op[i];
    end
    v[280] = s_en;
    return v;
  endfunction

  function automatic logic [OUT_W-1:0] model_out();
    logic [OUT_W-1:0] v = '0;
    bit all_zero = 1'b1;
    bit par = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      v[40*i +: 40] = m_acc[i];
      v[320 + i]    = m_sat[i];
      if (m_acc[i] != 0) all_zero = 1'b0;
      par = par ^ (^m_acc[i]);
    end
    v[328] = all_zero;
    v[329] = par;
    return v;
  endfunction

  function automatic void model_lane(int i, logic [2:0] op, logic [31:0] a);
    logic signed [39:0] acc_s = m_acc[i];
    logic signed [31:0] a_s = a;
    longint sacc = acc_s;
    longint sa = a_s;
    longint s;
    case (op)
      3'd0: ;
      3'd1: m_acc[i] = {8'h00, a};
      3'd2: m_acc[i] = 40'(sacc + sa);
      3'd3: m_acc[i] = 40'(sacc - sa);
      3'd4: m_acc[i] = m_acc[i] ^ {8'h00, a};
      3'd5: m_acc[i] = m_acc[i] << a[4:0];
      3'd6: begin m_acc[i] = '0; m_sat[i] = 1'b0; end
      default: begin
        s = sacc + sa;
        if (s > 64'sh7F_FFFF_FFFF) begin
          m_acc[i] = 40'h7F_FFFF_FFFF; m_sat[i] = 1'b1;
        end else if (s < -64'sh80_0000_0000) begin
          m_acc[i] = 40'h80_0000_0000; m_sat[i] = 1'b1;
        end else begin
          m_acc[i] = 40'(s);
        end
      end
    endcase
  endfunction

  // One clock: drive at the falling edge, advance the model, compare after the rising edge.
  task automatic cycle(input logic r);
    @(negedge clk);
    rst_n   = r;
    in_flat = pack_in();
    @(posedge clk);
    #1;
    if (r) begin
      for (int i = 0; i < LANES; i++) begin m_acc[i] = '0; m_sat[i] = 1'b0; end
    end else if (s_en) begin
      for (int i = 0; i < LANES; i++) model_lane(i, s_op[i], s_a[i]);
    end
    check("model", out_flat, model_out());
  endtask

  task automatic idle_ops();
    for (int i = 0; i < LANES; i++) begin s_op[i] = 3'd0; s_a[i] = $urandom; end
    s_en = 1'b1;
  endtask

  task automatic randomize_ops();
    for (int i = 0; i < LANES; i++) begin
      s_op[i] = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: s_a[i] = 32'h7FFF_FFFF;
        1: s_a[i] = 32'h8000_0000;
        default: s_a[i] = $urandom;
      endcase
    end
    s_en = ($urandom_range(0, 7) != 0);
  endtask

  initial begin
    for (int i = 0; i < LANES; i++) begin m_acc[i] = '0; m_sat[i] = 1'b0; end

    // Reset with random inputs for two edges.
    randomize_ops();
    cycle(1'b1);
    randomize_ops();
    cycle(1'b1);
    check("reset_vec", out_flat, RESET_VEC);

    // LOAD then ADD on lane 0.
    idle_ops(); s_op[0] = 3'd1; s_a[0] = 32'h0000_0005;
    cycle(1'b0);
    check("load_acc0", OUT_W'(out_flat[39:0]), OUT_W'(40'd5));
    check("zero_bit_after_load", OUT_W'(out_flat[328]), OUT_W'(1'b0));
    idle_ops(); s_op[0] = 3'd2; s_a[0] = 32'hFFFF_FFFF;
    cycle(1'b0);
    check("add_acc0", OUT_W'(out_flat[39:0]), OUT_W'(40'd4));

    // SADD saturation on lane 3.
    idle_ops(); s_op[3] = 3'd1; s_a[3] = 32'h7FFF_FFFF;
    cycle(1'b0);
    for (int k = 0; k < 300; k++) begin
      idle_ops(); s_op[3] = 3'd7; s_a[3] = 32'h7FFF_FFFF;
      cycle(1'b0);
    end
    check("sadd_acc3", OUT_W'(out_flat[120 +: 40]), OUT_W'(40'h7F_FFFF_FFFF));
    check("sadd_flag3", OUT_W'(out_flat[323]), OUT_W'(1'b1));
    idle_ops(); s_op[3] = 3'd6;
    cycle(1'b0);
    check("clr_acc3", OUT_W'(out_flat[120 +: 40]), OUT_W'(40'd0));
    check("clr_flag3", OUT_W'(out_flat[323]), OUT_W'(1'b0));

    // Enable gating: LOAD everywhere with en low.
    for (int i = 0; i < LANES; i++) begin s_op[i] = 3'd1; s_a[i] = 32'hA5A5_0000 | 32'(i + 1); end
    s_en = 1'b0;
    cycle(1'b0);
    check("en_low_acc0", OUT_W'(out_flat[39:0]), OUT_W'(40'd4));

    // Wrap: 0 - 1, then + 1 on lane 1.
    idle_ops(); s_op[1] = 3'd1; s_a[1] = 32'd0;
    cycle(1'b0);
    idle_ops(); s_op[1] = 3'd3; s_a[1] = 32'd1;
    cycle(1'b0);
    check("sub_wrap_acc1", OUT_W'(out_flat[40 +: 40]), OUT_W'(40'hFF_FFFF_FFFF));
    idle_ops(); s_op[1] = 3'd2; s_a[1] = 32'd1;
    cycle(1'b0);
    check("add_wrap_acc1", OUT_W'(out_flat[40 +: 40]), OUT_W'(40'd0));
    check("add_wrap_flag1", OUT_W'(out_flat[321]), OUT_W'(1'b0));

    // Shift on lane 2: 1 << 31 << 8, then shift by 0.
    idle_ops(); s_op[2] = 3'd1; s_a[2] = 32'd1;
    cycle(1'b0);
    idle_ops(); s_op[2] = 3'd5; s_a[2] = 32'd31;
    cycle(1'b0);
    idle_ops(); s_op[2] = 3'd5; s_a[2] = 32'd8;
    cycle(1'b0);
    check("shl39_acc2", OUT_W'(out_flat[80 +: 40]), OUT_W'(40'h80_0000_0000));
    idle_ops(); s_op[2] = 3'd5; s_a[2] = 32'hFFFF_FFE0;
    cycle(1'b0);
    check("shl0_acc2", OUT_W'(out_flat[80 +: 40]), OUT_W'(40'h80_0000_0000));

    // Random traffic with occasional resets.
    for (int k = 0; k < 600; k++) begin
      randomize_ops();
      cycle($urandom_range(0, 63) == 0);
    end

    // Mid-operation reset after 50 random cycles.
    for (int k = 0; k < 50; k++) begin
      randomize_ops();
      cycle(1'b0);
    end
    randomize_ops();
    cycle(1'b1);
    check("mid_reset_vec", out_flat, RESET_VEC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
